// File: rtl/batcharger_adcseq.sv
// ADC-side sequencer for the battery charger: time-multiplexes one 8-bit ADC
// over the voltage/current/temperature channels and reports when all enabled samples are fresh.
module batcharger_adcseq #(
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       vmonen,
  input  logic       imonen,
  input  logic       tmonen,
  output logic [1:0] adc_sel,
  output logic       adc_start,
  input  logic       adc_done,
  input  logic [7:0] adc_data,
  output logic [7:0] vbat,
  output logic [7:0] ibat,
  output logic [7:0] tbat,
  output logic       vtok,
  output logic       adc_err
);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_START, S_WAIT, S_STORE} state_e;

  localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

  state_e     state_q;
  logic [1:0] ch_q;
  logic [2:0] round_q;
  logic [7:0] settle_q;
  logic [7:0] tmo_q;
  logic [7:0] data_q;
  logic       wr_q;
  logic       fail_q;
  logic [1:0] sel_q;
  logic       start_q;
  logic [7:0] vbat_q, ibat_q, tbat_q;
  logic       vtok_q;
  logic       err_q;

  logic [2:0] live_mask;
  logic       mismatch;
  logic [2:0] rem_d;
  logic       last_d;
  logic [1:0] nxt_d;
  logic [1:0] first_d;

  function automatic logic [1:0] lowest(input logic [2:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else           return 2'd2;
  endfunction

  assign live_mask = {tmonen, imonen, vmonen};
  assign mismatch  = (live_mask != round_q);

  // Channels of the round mask still to be sampled after the current one.
  always_comb begin
    rem_d = 3'b000;
    case (ch_q)
      2'd0:    rem_d = {round_q[2:1], 1'b0};
      2'd1:    rem_d = {round_q[2], 2'b00};
      default: rem_d = 3'b000;
    endcase
  end

  assign last_d  = (rem_d == 3'b000);
  assign nxt_d   = lowest(rem_d);
  assign first_d = lowest(live_mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ch_q     <= 2'd0;
      round_q  <= 3'b000;
      settle_q <= 8'd0;
      tmo_q    <= 8'd0;
      data_q   <= 8'h00;
      wr_q     <= 1'b0;
      fail_q   <= 1'b0;
      sel_q    <= 2'b00;
      start_q  <= 1'b0;
      vbat_q   <= 8'h00;
      ibat_q   <= 8'h00;
      tbat_q   <= 8'h00;
      vtok_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (!en) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      settle_q <= 8'd0;
      tmo_q    <= 8'd0;
      wr_q     <= 1'b0;
      fail_q   <= 1'b0;
      vtok_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (live_mask != 3'b000) begin
            round_q  <= live_mask;
            ch_q     <= first_d;
            sel_q    <= first_d;
            settle_q <= 8'd0;
            fail_q   <= 1'b0;
            state_q  <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            settle_q <= 8'd0;
            start_q  <= 1'b1;
            state_q  <= S_START;
          end else begin
            settle_q <= settle_q + 8'd1;
          end
        end
        S_START: begin
          tmo_q   <= 8'd0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (adc_done) begin
            data_q  <= adc_data;
            wr_q    <= 1'b1;
            state_q <= S_STORE;
          end else if (tmo_q == TIMEOUT_LAST) begin
            // Abandon the conversion: pass through STORE without writing.
            tmo_q   <= 8'd0;
            wr_q    <= 1'b0;
            err_q   <= 1'b1;
            fail_q  <= 1'b1;
            vtok_q  <= 1'b0;
            state_q <= S_STORE;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        S_STORE: begin
          if (wr_q) begin
            case (ch_q)
              2'd0:    vbat_q <= data_q;
              2'd1:    ibat_q <= data_q;
              default: tbat_q <= data_q;
            endcase
          end
          if (last_d) begin
            if (!fail_q && !mismatch) vtok_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            ch_q     <= nxt_d;
            sel_q    <= nxt_d;
            settle_q <= 8'd0;
            state_q  <= S_SETTLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // A live mask that no longer matches the round invalidates both vtok and the round.
      if (mismatch) begin
        vtok_q <= 1'b0;
        if (state_q != S_IDLE) fail_q <= 1'b1;
      end
    end
  end

  assign adc_sel   = sel_q;
  assign adc_start = start_q;
  assign vbat      = vbat_q;
  assign ibat      = ibat_q;
  assign tbat      = tbat_q;
  assign vtok      = vtok_q;
  assign adc_err   = err_q;

endmodule

// File: tb/tb_batcharger_adcseq.sv
// Scoreboard bench for batcharger_adcseq: an ADC responder feeds random data and
// updates a channel-level model; a monitor checks every conversion start against it.
module tb_batcharger_adcseq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       vmonen = 1'b0, imonen = 1'b0, tmonen = 1'b0;
  logic [1:0] adc_sel;
  logic       adc_start;
  logic       adc_done;
  logic [7:0] adc_data;
  logic [7:0] vbat, ibat, tbat;
  logic       vtok, adc_err;

  logic       r_done = 1'b0, m_done = 1'b0;
  logic [7:0] r_data = 8'h00, m_data = 8'h00;
  bit         resp_on = 1'b0, mon_on = 1'b0;

  assign adc_done = resp_on ? r_done : m_done;
  assign adc_data = resp_on ? r_data : m_data;

  typedef struct {
    logic [1:0] ch;
    bit         last;
    bit         stale;
  } ent_t;

  ent_t       rnd_q[$];
  logic [1:0] exp_q[$];
  logic [7:0] fix_q[$];
  logic [7:0] last_val[3];
  bit         vtok_m = 1'b0, err_m = 1'b0, rfail = 1'b0, prev_start = 1'b0;
  int         conv_idx = 0, drop_idx = -1, done_cnt = 0, pushed = 0;
  int         total = 0, bad = 0;

  batcharger_adcseq #(.SETTLE_CYC(4), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst), .en(en),
    .vmonen(vmonen), .imonen(imonen), .tmonen(tmonen),
    .adc_sel(adc_sel), .adc_start(adc_start),
    .adc_done(adc_done), .adc_data(adc_data),
    .vbat(vbat), .ibat(ibat), .tbat(tbat),
    .vtok(vtok), .adc_err(adc_err)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // One round samples the enabled channels in ascending order; the highest one closes it.
  task automatic push_round(input logic [2:0] m, input bit stale);
    int hi = 0;
    for (int c = 0; c < 3; c++) if (m[c]) hi = c;
    for (int c = 0; c < 3; c++) begin
      if (m[c]) begin
        ent_t e;
        e.ch = 2'(c);
        e.last = (c == hi);
        e.stale = stale;
        rnd_q.push_back(e);
        exp_q.push_back(2'(c));
        pushed++;
      end
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_vbat"}, int'(vbat), int'(last_val[0]));
    chk({tag, "_ibat"}, int'(ibat), int'(last_val[1]));
    chk({tag, "_tbat"}, int'(tbat), int'(last_val[2]));
    chk({tag, "_vtok"}, int'(vtok), int'(vtok_m));
    chk({tag, "_err"}, int'(adc_err), int'(err_m));
  endtask

  task automatic wait_all(input string tag);
    int n = 0;
    while (!(done_cnt == pushed && exp_q.size() == 0) && n < 4000) begin
      @(posedge clk);
      n++;
    end
    chk({tag, "_complete"}, done_cnt, pushed);
    repeat (3) @(negedge clk);
    check_regs(tag);
  endtask

  task automatic run_phase(input string tag, input logic [2:0] m, input int rounds, input int drop);
    en = 1'b0;
    repeat (2) @(negedge clk);
    chk({tag, "_enlow_vtok"}, int'(vtok), 0);
    chk({tag, "_enlow_err"}, int'(adc_err), 0);
    vtok_m = 1'b0; err_m = 1'b0; rfail = 1'b0;
    conv_idx = 0; drop_idx = drop;
    {tmonen, imonen, vmonen} = m;
    for (int r = 0; r < rounds; r++) push_round(m, 1'b0);
    en = 1'b1;
    wait_all(tag);
  endtask

  // ADC responder: answers each start with random latency/data or a deliberate timeout.
  always begin : responder
    ent_t       e;
    int         lat;
    logic [7:0] d;
    @(negedge clk);
    r_done = 1'b0;
    if (resp_on && adc_start && rnd_q.size() > 0) begin
      e = rnd_q.pop_front();
      if (conv_idx == drop_idx) begin
        repeat (64) @(negedge clk);
        chk("tmo_not_early", int'(adc_err), int'(err_m));
        @(negedge clk);
        err_m = 1'b1; vtok_m = 1'b0; rfail = 1'b1;
        chk("tmo_err_set", int'(adc_err), 1);
      end else begin
        lat = $urandom_range(1, 6);
        repeat (lat) @(negedge clk);
        d = (fix_q.size() > 0) ? fix_q.pop_front() : 8'($urandom);
        r_done = 1'b1; r_data = d;
        last_val[e.ch] = d;
        @(negedge clk);
        r_done = 1'b0; r_data = 8'($urandom);
      end
      conv_idx++;
      if (e.last) begin
        if (!rfail && !e.stale) vtok_m = 1'b1;
        rfail = 1'b0;
      end
      done_cnt++;
    end else if (resp_on && $urandom_range(0, 3) == 0) begin
      r_done = 1'b1; r_data = 8'hFF;   // spurious done outside WAIT
    end
  end

  always @(negedge clk) begin : monitor
    if (mon_on) begin
      chk("sel_legal", int'(adc_sel != 2'b11), 1);
      if (adc_start) begin
        chk("start_width", int'(prev_start), 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_start", int'(adc_start), 0);
        end else begin
          chk("sel_order", int'(adc_sel), int'(exp_q.pop_front()));
          check_regs("at_start");
        end
      end
    end
    prev_start = adc_start;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    for (int c = 0; c < 3; c++) last_val[c] = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_sel", int'(adc_sel), 0);
    chk("rst_start", int'(adc_start), 0);
    chk("rst_vbat", int'(vbat), 0);
    chk("rst_ibat", int'(ibat), 0);
    chk("rst_tbat", int'(tbat), 0);
    chk("rst_vtok", int'(vtok), 0);
    chk("rst_err", int'(adc_err), 0);
    rst = 1'b0;
    @(negedge clk);

    // Voltage only: start on the 5th cycle after leaving IDLE, data three cycles later.
    en = 1'b1; vmonen = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("v_sel", int'(adc_sel), 0);
      chk("v_start_cycle", int'(adc_start), int'(i == 5));
    end
    repeat (3) @(negedge clk);
    m_done = 1'b1; m_data = 8'hA3;
    @(negedge clk);
    m_done = 1'b0; m_data = 8'h00;
    chk("v_before_store", int'(vbat), 0);
    @(negedge clk);
    chk("v_vbat", int'(vbat), 8'hA3);
    chk("v_vtok", int'(vtok), 1);
    chk("v_ibat", int'(ibat), 0);
    chk("v_tbat", int'(tbat), 0);
    last_val[0] = 8'hA3;

    prev_start = 1'b0;
    mon_on = 1'b1; resp_on = 1'b1;
    fix_q.push_back(8'h93); fix_q.push_back(8'h40); fix_q.push_back(8'h7F);
    run_phase("all3", 3'b111, 1, -1);
    for (int p = 0; p < 3; p++)
      run_phase("rand", 3'($urandom_range(1, 7)), $urandom_range(1, 3), -1);

    // Mask change after a clean {V,T} round: in-flight round is stale, next one samples V,I,T.
    run_phase("vt", 3'b101, 2, -1);
    imonen = 1'b1; vtok_m = 1'b0;
    push_round(3'b101, 1'b1);
    push_round(3'b111, 1'b0);
    @(negedge clk);
    chk("mask_vtok_fall", int'(vtok), 0);
    wait_all("mask");

    run_phase("tmo", 3'b001, 3, 0);

    // en drop in WAIT, then asynchronous reset in SETTLE.
    mon_on = 1'b0; resp_on = 1'b0; m_done = 1'b0;
    begin
      int n = 0;
      while (!adc_start && n < 30) begin
        @(negedge clk);
        n++;
      end
    end
    chk("restart_seen", int'(adc_start), 1);
    chk("err_sticky", int'(adc_err), 1);
    chk("vtok_before_drop", int'(vtok), 1);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("drop_vtok", int'(vtok), 0);
    chk("drop_err", int'(adc_err), 0);
    chk("drop_vbat_hold", int'(vbat), int'(last_val[0]));
    repeat (6) begin
      @(negedge clk);
      chk("no_start_en_low", int'(adc_start), 0);
    end
    en = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_sel", int'(adc_sel), 0);
    chk("arst_start", int'(adc_start), 0);
    chk("arst_vbat", int'(vbat), 0);
    chk("arst_ibat", int'(ibat), 0);
    chk("arst_tbat", int'(tbat), 0);
    chk("arst_vtok", int'(vtok), 0);
    chk("arst_err", int'(adc_err), 0);
    @(negedge clk);
    rst = 1'b0;
    en = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
